// File: rtl/fp16_addsub_sequencer_pkg.sv
// Shared types and constants for the FP16 add/subtract sequencer.
// Fixes the field layout of FP16 words and of the 16-bit working mantissa.
package fp16_pkg;

    localparam int WM       = 16;
    localparam int EXP_W    = 5;
    localparam int FRAC_W   = 10;
    localparam int SIGN_BIT = 15;
    localparam int EXP_HI   = 14;
    localparam int EXP_LO   = 10;

    // Working mantissa: [13] carry, [12] hidden, [11:2] fraction, [1] guard, [0] round
    localparam int M_CARRY  = 13;
    localparam int M_HIDDEN = 12;

    localparam logic [5:0]  EXP_MAX   = 6'd30;
    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        EXC_NONE = 2'b00,
        EXC_OVF  = 2'b01,
        EXC_UNF  = 2'b10,
        EXC_INV  = 2'b11
    } exc_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    // Expand an FP16 word into the working mantissa; exp==0 operands flush to zero.
    function automatic logic [WM-1:0] unpack_mant(input logic [15:0] v);
        if (v[EXP_HI:EXP_LO] == '0)
            return '0;
        return {3'b000, 1'b1, v[FRAC_W-1:0], 2'b00};
    endfunction

endpackage

// File: rtl/fp16_addsub_sequencer_if.sv
// Operand/result handshake bundle between the ALU top level and the FP16 sequencer.
// master drives operands and out_ready; slave is the sequencer.
interface fp16_addsub_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [1:0]  exception;
    logic        busy;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, exception, busy
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, exception, busy
    );
endinterface

// File: rtl/fp16_addsub_sequencer_round.sv
// Combinational rounding of a normalised mantissa; RNE when FP16_RNE_ROUND_EN is defined, else truncation.
// Zero latency; no handshake.
module fp16_round
    import fp16_pkg::*;
(
    input  logic [12:0]       m,
    input  logic              sticky,
    output logic [FRAC_W-1:0] frac,
    output logic              carry
);
    logic [13:0] sum;
    logic        unused_low;

`ifdef FP16_RNE_ROUND_EN
    logic inc;
    assign inc = m[1] & (m[0] | sticky | m[2]);
    assign sum = {1'b0, m} + {11'd0, inc, 2'b00};
`else
    logic unused_sticky;
    assign unused_sticky = sticky;
    assign sum = {1'b0, m};
`endif

    assign unused_low = ^sum[1:0];
    assign carry      = sum[13];
    // A carry leaves 1.000..., so the renormalised fraction is taken one bit higher.
    assign frac       = carry ? sum[12:3] : sum[11:2];

endmodule

// File: rtl/fp16_addsub_sequencer.sv
// FP16 add/subtract with one shared 1-bit shifter; (cnt+1)+1+n_norm+1 cycles, special operands finish on accept.
// Accepts only in IDLE; holds result in DONE until out_ready. Rounding mode set by FP16_RNE_ROUND_EN.
module fp16_addsub_sequencer
    import fp16_pkg::*;
#(
    parameter int MAX_ALIGN = 14
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    fp16_addsub_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(MAX_ALIGN + 1);
    localparam logic [5:0]       MAX_ALIGN_E = 6'(MAX_ALIGN);
    localparam logic [CNT_W-1:0] MAX_ALIGN_C = CNT_W'(MAX_ALIGN);

    state_t           state_q, state_d;
    logic [WM-1:0]    x_q, x_d;
    logic [WM-1:0]    y_q, y_d;
    logic [5:0]       exp_q, exp_d;
    logic             sign_q, sign_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             eff_sub_q, eff_sub_d;
    logic             both_neg_q, both_neg_d;
    logic [15:0]      result_q, result_d;
    exc_t             exc_q, exc_d;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic             a_zero, b_zero, b_sign_eff, a_big, special;
    logic [5:0]       diff;
    logic [FRAC_W-1:0] rnd_frac;
    logic             rnd_carry;
    logic [5:0]       exp_r;

    assign a_exp      = bus.a[EXP_HI:EXP_LO];
    assign b_exp      = bus.b[EXP_HI:EXP_LO];
    assign a_zero     = (a_exp == '0);
    assign b_zero     = (b_exp == '0);
    assign b_sign_eff = bus.b[SIGN_BIT] ^ bus.sub;
    assign special    = (a_exp == '1) || (b_exp == '1);
    // Ties keep A in X so an exact cancellation takes A's sign path.
    assign a_big      = (a_zero ? 15'h0 : bus.a[EXP_HI:0]) >= (b_zero ? 15'h0 : bus.b[EXP_HI:0]);
    assign diff       = a_big ? ({1'b0, a_exp} - {1'b0, b_exp}) : ({1'b0, b_exp} - {1'b0, a_exp});

    fp16_round u_round (
        .m      (x_q[M_HIDDEN:0]),
        .sticky (sticky_q),
        .frac   (rnd_frac),
        .carry  (rnd_carry)
    );

    assign exp_r = exp_q + {5'd0, rnd_carry};

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        eff_sub_d  = eff_sub_q;
        both_neg_d = both_neg_q;
        result_d   = result_q;
        exc_d      = exc_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (special) begin
                        result_d = FP16_QNAN;
                        exc_d    = EXC_INV;
                        state_d  = DONE;
                    end else begin
                        x_d        = a_big ? unpack_mant(bus.a) : unpack_mant(bus.b);
                        y_d        = a_big ? unpack_mant(bus.b) : unpack_mant(bus.a);
                        exp_d      = {1'b0, (a_big ? a_exp : b_exp)};
                        sign_d     = a_big ? bus.a[SIGN_BIT] : b_sign_eff;
                        eff_sub_d  = bus.a[SIGN_BIT] ^ b_sign_eff;
                        both_neg_d = bus.a[SIGN_BIT] & b_sign_eff;
                        sticky_d   = 1'b0;
                        cnt_d      = (diff > MAX_ALIGN_E) ? MAX_ALIGN_C : diff[CNT_W-1:0];
                        state_d    = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = ADD;
                end else begin
                    y_d      = y_q >> 1;
                    sticky_d = sticky_q | y_q[0];
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            ADD: begin
                x_d     = eff_sub_q ? (x_q - y_q) : (x_q + y_q);
                state_d = NORM;
            end
            NORM: begin
                if (x_q == '0) begin
                    result_d = {both_neg_q, 15'h0};
                    exc_d    = EXC_NONE;
                    state_d  = DONE;
                end else if (x_q[M_CARRY]) begin
                    x_d      = x_q >> 1;
                    sticky_d = sticky_q | x_q[0];
                    exp_d    = exp_q + 6'd1;
                end else if (!x_q[M_HIDDEN]) begin
                    x_d   = x_q << 1;
                    exp_d = exp_q - 6'd1;
                    if (exp_q == 6'd1) begin
                        result_d = {sign_q, 15'h0};
                        exc_d    = EXC_UNF;
                        state_d  = DONE;
                    end
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                exp_d = exp_r;
                if (exp_r > EXP_MAX) begin
                    result_d = {sign_q, 5'h1F, 10'h000};
                    exc_d    = EXC_OVF;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], rnd_frac};
                    exc_d    = EXC_NONE;
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
            eff_sub_q  <= 1'b0;
            both_neg_q <= 1'b0;
            result_q   <= '0;
            exc_q      <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
            eff_sub_q  <= eff_sub_d;
            both_neg_q <= both_neg_d;
            result_q   <= result_d;
            exc_q      <= exc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.exception = exc_q;

endmodule

// File: tb/tb_fp16_addsub_sequencer.sv
// Directed-vector bench for fp16_addsub_sequencer with an arithmetic reference model
// checked on every out_valid cycle; honours FP16_RNE_ROUND_EN like the design.
module tb_fp16_addsub_sequencer;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] res;
        logic [1:0]  exc;
        int          lat;   // edges after the accept edge until out_valid; -1 = not checked
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [15:0] mdl_res;
    logic [1:0]  mdl_exc;
    vec_t vecs[14];

    fp16_addsub_sequencer_if bus();

    fp16_addsub_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: align by an arithmetic shift, normalise to [4096,8192), round, pack.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                  output logic [15:0] r, output logic [1:0] e);
        int ea, eb, ex, ey, mx, my, d, sh, m, stk;
        logic sa, sb, sx;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        sa = a[15];
        sb = b[15] ^ s;
        if (ea == 31 || eb == 31) begin
            r = 16'h7E00; e = 2'b11; return;
        end
        if (((ea == 0) ? 0 : int'(a[14:0])) >= ((eb == 0) ? 0 : int'(b[14:0]))) begin
            ex = ea; mx = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 4; sx = sa;
            ey = eb; my = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 4;
        end else begin
            ex = eb; mx = (eb == 0) ? 0 : (1024 + int'(b[9:0])) * 4; sx = sb;
            ey = ea; my = (ea == 0) ? 0 : (1024 + int'(a[9:0])) * 4;
        end
        d   = ex - ey;
        sh  = (d > 14) ? 14 : d;
        stk = ((my % (1 << sh)) != 0) ? 1 : 0;
        my  = my >> sh;
        m   = (sa == sb) ? mx + my : mx - my;
        if (m == 0) begin
            r = (sa && sb) ? 16'h8000 : 16'h0000; e = 2'b00; return;
        end
        while (m >= 8192) begin
            stk = stk | (m & 1); m = m >> 1; ex = ex + 1;
        end
        while (m < 4096) begin
            m = m << 1; ex = ex - 1;
            if (ex == 0) begin
                r = {sx, 15'h0}; e = 2'b10; return;
            end
        end
`ifdef FP16_RNE_ROUND_EN
        if (((m >> 1) & 1) == 1 && ((m & 1) == 1 || stk == 1 || ((m >> 2) & 1) == 1))
            m = m + 4;
        if (m >= 8192) begin
            m = m >> 1; ex = ex + 1;
        end
`endif
        if (ex > 30) begin
            r = {sx, 5'h1F, 10'h0}; e = 2'b01;
        end else begin
            r = {sx, ex[4:0], m[11:2]}; e = 2'b00;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Every cycle a result is presented it must match the model and block new input.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            n_cmp++;
            if (bus.result !== mdl_res || bus.exception !== mdl_exc) begin
                n_err++;
                $display("FAIL model: got %h/%b, expected %h/%b", bus.result, bus.exception, mdl_res, mdl_exc);
            end
            check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
        end
    end

    task automatic run_op(input vec_t v);
        int lat;
        model(v.a, v.b, v.sub, mdl_res, mdl_exc);
        @(negedge clk);
        check($sformatf("in_ready_before_%h_%h", v.a, v.b), 32'(bus.in_ready), 32'd1);
        bus.a = v.a; bus.b = v.b; bus.sub = v.sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            check($sformatf("timeout_%h_%h", v.a, v.b), 32'(bus.out_valid), 32'd1);
            return;
        end
        check($sformatf("result_%h_%h_%b", v.a, v.b, v.sub), 32'(bus.result), 32'(v.res));
        check($sformatf("exc_%h_%h_%b", v.a, v.b, v.sub), 32'(bus.exception), 32'(v.exc));
        if (v.lat >= 0)
            check($sformatf("latency_%h_%h", v.a, v.b), 32'(lat), 32'(v.lat));
        if (bus.out_ready) begin
            @(posedge clk); #1;
            check("out_valid_drop", 32'(bus.out_valid), 32'd0);
            check("in_ready_return", 32'(bus.in_ready), 32'd1);
        end
    endtask

    initial begin
        vecs[0]  = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00, 5};
        vecs[1]  = '{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 2'b00, -1};
        vecs[2]  = '{16'h0401, 16'h0400, 1'b1, 16'h0000, 2'b10, -1};
        vecs[3]  = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 2'b01, 5};
        // Special operands are resolved on the accept edge itself.
        vecs[4]  = '{16'h7C00, 16'h3C00, 1'b0, 16'h7E00, 2'b11, 0};
`ifdef FP16_RNE_ROUND_EN
        vecs[5]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 2'b00, 15};
`else
        vecs[5]  = '{16'h3C01, 16'h1000, 1'b0, 16'h3C01, 2'b00, 15};
`endif
        vecs[6]  = '{16'h3C00, 16'h0001, 1'b0, 16'h3C00, 2'b00, 18};
        vecs[7]  = '{16'h4200, 16'hC000, 1'b0, 16'h3C00, 2'b00, 5};
        vecs[8]  = '{16'h3C00, 16'h3800, 1'b1, 16'h3800, 2'b00, 6};
        vecs[9]  = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 2'b00, -1};
        vecs[10] = '{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 2'b00, 15};
        vecs[11] = '{16'hBC00, 16'hBC00, 1'b0, 16'hC000, 2'b00, 5};
        vecs[12] = '{16'h5800, 16'h3C00, 1'b0, 16'h5808, 2'b00, 11};
        vecs[13] = '{16'h3C01, 16'h3C00, 1'b1, 16'h1400, 2'b00, 14};

        clk = 1'b0; rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        mdl_res = '0; mdl_exc = '0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", 32'(bus.result), 32'h0000);
        check("rst_exception", 32'(bus.exception), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure: result must sit unchanged in DONE while out_ready is low.
        bus.out_ready = 1'b0;
        run_op(vecs[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result", 32'(bus.result), 32'h4000);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        run_op(vecs[7]);

        // Reset while aligning 5800+3C00 must clear everything at once.
        @(negedge clk);
        bus.a = 16'h5800; bus.b = 16'h3C00; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_result", 32'(bus.result), 32'h0000);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk); rst_n = 1'b1;
        run_op(vecs[12]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
